// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and stage-count helper for the pipelined adder/subtractor
package rca_pkg;

  typedef enum logic {
    RCA_ADD = 1'b0,
    RCA_SUB = 1'b1
  } rca_op_e;

  function automatic int rca_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// rtl/rca_seg.sv - M-bit combinational ripple-carry segment
module rca_seg #(
  parameter int M = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         cin,
  output logic [M-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [M:0] c;

  // Ripple the carry bit by bit; c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < M; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[M];
  assign c_msb = c[M-1];

endmodule

// File: rtl/rca_pipe_n.sv
// rtl/rca_pipe_n.sv - pipelined WIDTH-bit add/sub, one M-bit segment per stage; RCA_PIPE_OVF_EN adds ovf
module rca_pipe_n
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int M     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int S = rca_stages(WIDTH, M);

  if (WIDTH % M != 0) begin : g_width_check
    $error("rca_pipe_n: WIDTH must be a multiple of M");
  end

  logic             en;
  logic [WIDTH-1:0] b_x;

  // Per-stage state: a_q/b_q hold the operand bits not yet consumed, shifted
  // down so the next segment always reads bits [M-1:0].
  logic [S-1:0]     vld_q;
  logic [S-1:0]     op_q;
  logic [S-1:0]     c_q;
  logic [WIDTH-1:0] sum_q [S];
  logic [WIDTH-1:0] a_q   [S];
  logic [WIDTH-1:0] b_q   [S];

  logic [M-1:0]     seg_a     [S];
  logic [M-1:0]     seg_b     [S];
  logic             seg_cin   [S];
  logic [M-1:0]     seg_s     [S];
  logic             seg_cout  [S];
  logic             seg_c_msb [S];
  logic             unused_taps;

`ifdef RCA_PIPE_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`endif

  assign out_valid = vld_q[S-1];
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign b_x       = (rca_op_e'(op) == RCA_SUB) ? ~B : B;
  assign Sum       = sum_q[S-1];
  assign C_out     = c_q[S-1];

  for (genvar k = 0; k < S; k++) begin : g_seg
    if (k == 0) begin : g_first
      assign seg_a[k]   = A[M-1:0];
      assign seg_b[k]   = b_x[M-1:0];
      assign seg_cin[k] = op;
    end else begin : g_next
      assign seg_a[k]   = a_q[k-1][M-1:0];
      assign seg_b[k]   = b_q[k-1][M-1:0];
      assign seg_cin[k] = c_q[k-1];
    end
    rca_seg #(.M(M)) u_seg (
      .a     (seg_a[k]),
      .b     (seg_b[k]),
      .cin   (seg_cin[k]),
      .s     (seg_s[k]),
      .cout  (seg_cout[k]),
      .c_msb (seg_c_msb[k])
    );
  end

  // Final stage keeps no use for its op and leftover operands; lower segments' c_msb is only a tap.
  always_comb begin
    unused_taps = op_q[S-1] ^ (^a_q[S-1]) ^ (^b_q[S-1]);
    for (int k = 0; k < S; k++) begin
      unused_taps = unused_taps ^ seg_c_msb[k];
    end
  end

  // Whole pipeline advances together under en; bubbles travel like data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      op_q  <= '0;
      c_q   <= '0;
      for (int k = 0; k < S; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
`ifdef RCA_PIPE_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (en) begin
      vld_q[0] <= in_valid;
      op_q[0]  <= op;
      c_q[0]   <= seg_cout[0];
      sum_q[0] <= WIDTH'(seg_s[0]);
      a_q[0]   <= A >> M;
      b_q[0]   <= b_x >> M;
      for (int k = 1; k < S; k++) begin
        vld_q[k]            <= vld_q[k-1];
        op_q[k]             <= op_q[k-1];
        c_q[k]              <= seg_cout[k];
        sum_q[k]            <= sum_q[k-1];
        sum_q[k][k*M +: M]  <= seg_s[k];
        a_q[k]              <= a_q[k-1] >> M;
        b_q[k]              <= b_q[k-1] >> M;
      end
`ifdef RCA_PIPE_OVF_EN
      ovf_q <= seg_c_msb[S-1] ^ seg_cout[S-1];
`endif
    end
  end

endmodule

// File: doc/rca_pipe_n.md
# rca_pipe_n

Pipelined, parametrised ripple-carry adder/subtractor, the next generation of `RCA_N`. The WIDTH-bit operation is split into S = WIDTH/M ripple segments of M bits, each in its own pipeline stage, so the carry chain per cycle is only M bits long. Adds a per-transaction add/subtract mode and a valid/ready handshake with backpressure. Sits in the arithmetic datapath wherever a wide adder must close timing at full clock rate with one result per cycle.

## Interface
- `WIDTH`, 16: operand and result width in bits.
- `M`, 4: segment width in bits. WIDTH % M must be 0, else elaboration `$error`. S = WIDTH/M stages.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: operands valid.
- `in_ready`  out  1: block can accept operands this cycle.
- `A`  in  WIDTH: operand A, unsigned.
- `B`  in  WIDTH: operand B, unsigned.
- `op`  in  1: 0 = A+B, 1 = A−B.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts result.
- `Sum`  out  WIDTH: result, modulo 2^WIDTH.
- `C_out`  out  1: carry out. For subtract this is the no-borrow flag: 1 when A ≥ B.
- `ovf`  out  1: signed overflow. Present only with `RCA_PIPE_OVF_EN`.

## Operation
- Subtract is implemented as A + ~B + 1: segment 0 carry-in = op; B is inverted when op = 1.
- Segment 0 is computed combinationally from the inputs and captured in stage register 0.
- Stage register k (0..S−1) holds:
  - valid bit
  - op
  - carry out of segment k
  - sum bits [(k+1)·M−1:0]
  - the not-yet-used upper bits of A and (conditionally inverted) B
- Segment k+1 adds its M bits using the registered carry from stage k.
- Stage S−1 is the output register. It drives `Sum`, `C_out` and `ovf` directly, with no output combinational logic.
- Global advance enable: en = ~out_valid | out_ready.
  - All stages shift together when en = 1 and hold when en = 0.
  - Bubbles are not compressed.
- `in_ready` = en. A transfer occurs when in_valid & in_ready.
- Stage 0 valid loads in_valid & en. When in_valid = 0 under en, a bubble (valid = 0) enters the pipeline.
- `out_valid` = stage S−1 valid bit.
- A result transfers to the consumer when out_valid & out_ready.
- M = WIDTH gives S = 1: a single registered adder.

## Timing
- Latency: operands accepted at rising edge t appear with out_valid = 1 after edge t+S−1, i.e. S cycles of register delay from input to stable output. With WIDTH=16, M=4 that is 4 edges.
- Throughput: one transaction per cycle while out_ready = 1.
- Stall: when out_valid = 1 and out_ready = 0:
  - `in_ready` = 0 in the same cycle (combinational path from out_ready).
  - All stage registers and outputs hold.
  - Release resumes on the next edge with no loss or duplication.
- Result values at reset:
  - `Sum` = 0, `C_out` = 0, `ovf` = 0
  - `out_valid` = 0, all stage valid bits = 0
  - `in_ready` = 1
- Reset asserted mid-operation clears all in-flight transactions immediately (asynchronous). Nothing is emitted for them.
- Simultaneous input accept and output drain in the same cycle is legal and is the steady-streaming case.
- Wrap-around: 0xFFFF + 0x0001 gives Sum = 0x0000 and C_out = 1.

## Configuration
- `RCA_PIPE_OVF_EN` defined:
  - Port `ovf` exists, registered alongside `Sum`.
  - ovf = carry into MSB XOR carry out of MSB, valid for both add and subtract under two's-complement interpretation.
  - The final stage additionally captures carry-into-MSB.
- Not defined: port `ovf` and its logic are absent. All other behaviour is identical.

## Structure
- Package `rca_pkg`:
  - `rca_op_e` enum (`RCA_ADD` = 0, `RCA_SUB` = 1)
  - localparam helper function for stage count S
- Sub-module `rca_seg`: M-bit combinational ripple segment.
  - Inputs: a, b, cin.
  - Outputs: s, cout, and c_msb (carry into top bit, used for ovf).
  - Instantiated S times in a generate loop.
- Top module `rca_pipe_n` holds the stage registers and handshake.

## Test plan
All scenarios use WIDTH=16, M=4.
1. A=16, B=16, op=0, out_ready=1 → Sum=32, C_out=0, out_valid high exactly 4 edges after accept.
2. Back-to-back accepts, one per cycle: (55,65,add), (5,2,add), (100,100,add) → Sum=120, 7, 200 on consecutive cycles, in order, no gaps.
3. Subtract cases:
   - 5−2 → Sum=3, C_out=1.
   - 2−5 → Sum=0xFFFD, C_out=0.
   - With macro: 0x8000−1 → Sum=0x7FFF, ovf=1.
4. Wrap: 0xFFFF+0x0001 → Sum=0, C_out=1. With macro: 0x7FFF+1 → ovf=1.
5. Stall: stream 4 adds, hold out_ready=0 for 3 cycles once out_valid=1 → Sum held stable, in_ready=0 throughout; after release all 4 results emerge in order, none dropped or duplicated.
6. Reset mid-flight: accept 2 transactions, pull rst_n low 1 cycle before the first result → out_valid=0, Sum=0, in_ready=1 at once; no stale result appears afterwards.
